// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between a sync_fifo_param instance and its
// producer/consumer logic. The FIFO takes the slave modport.
interface sync_fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr, rd, data_in,
        input  data_out, count, empty, full, almost_empty, almost_full,
               overflow, underflow
    );

    modport slave (
        input  flush, wr, rd, data_in,
        output data_out, count, empty, full, almost_empty, almost_full,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock first-word-fall-through FIFO with occupancy count, programmable
// almost flags, synchronous flush and sticky overflow/underflow indicators.
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic           clk,
    input  logic           reset,
    sync_fifo_param_if.slave fifo
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic full, empty, wr_ok, rd_ok, mem_we;

    // Full/empty come from the registered count only, so acceptance is judged
    // on pre-edge state and a full FIFO never passes a write through on a read.
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign wr_ok  = fifo.wr & ~full;
    assign rd_ok  = fifo.rd & ~empty;
    assign mem_we = wr_ok & ~fifo.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (fifo.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
            if (wr_ok && !rd_ok)      count_d = count_q + CW'(1);
            else if (rd_ok && !wr_ok) count_d = count_q - CW'(1);
            if (fifo.wr && full)  ovf_d = 1'b1;
            if (fifo.rd && empty) unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            if (mem_we) mem_q[wr_ptr_q] <= fifo.data_in;
        end
    end

    // Every output is a decode of registered state: no path from wr/rd/data_in.
    assign fifo.data_out     = mem_q[rd_ptr_q];
    assign fifo.count        = count_q;
    assign fifo.empty        = empty;
    assign fifo.full         = full;
    assign fifo.almost_empty = (count_q <= CW'(AE_THRESH));
    assign fifo.almost_full  = (count_q >= CW'(AF_THRESH));
    assign fifo.overflow     = ovf_q;
    assign fifo.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (WIDTH=8, DEPTH=8, AF=6, AE=1).
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) bus ();

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1)) dut (
        .clk   (clk),
        .reset (reset),
        .fifo  (bus.slave)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr = 1'b0; bus.rd = 1'b0; bus.flush = 1'b0; bus.data_in = 8'h00;
    endtask

    // {empty, full, almost_empty, almost_full, overflow, underflow}
    function automatic logic [5:0] flags();
        return {bus.empty, bus.full, bus.almost_empty, bus.almost_full,
                bus.overflow, bus.underflow};
    endfunction

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (bus.count !== 4'd0) begin
            errors++; $display("FAIL reset_count got %0d exp 0", bus.count);
        end
        checks++;
        if (flags() !== 6'b101000) begin
            errors++; $display("FAIL reset_flags got %b exp 101000", flags());
        end
        checks++;
        if (bus.data_out !== 8'h00) begin
            errors++; $display("FAIL reset_data got %h exp 00", bus.data_out);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp;
        for (int i = 1; i <= 8; i++) begin
            bus.wr = 1'b1; bus.data_in = 8'(i * 8'h11);
            tick();
            checks++;
            if (bus.count !== 4'(i)) begin
                errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus.count, i);
            end
            checks++;
            if ({bus.almost_full, bus.full, bus.almost_empty} !== {i >= 6, i == 8, i <= 1}) begin
                errors++;
                $display("FAIL fill_flags[%0d] af/full/ae got %b%b%b exp %b%b%b", i,
                         bus.almost_full, bus.full, bus.almost_empty, i >= 6, i == 8, i <= 1);
            end
        end
        idle();
        for (int i = 1; i <= 8; i++) begin
            exp = 8'(i * 8'h11);
            checks++;
            if (bus.data_out !== exp) begin
                errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, bus.data_out, exp);
            end
            bus.rd = 1'b1;
            tick();
        end
        idle();
        checks++;
        if (flags() !== 6'b101000 || bus.count !== 4'd0) begin
            errors++; $display("FAIL drain_end flags %b count %0d exp 101000 0", flags(), bus.count);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        for (int i = 1; i <= 8; i++) begin
            bus.wr = 1'b1; bus.data_in = 8'(i * 8'h11);
            tick();
        end
        bus.wr = 1'b1; bus.rd = 1'b1; bus.data_in = 8'hAA;
        tick();
        idle();
        checks++;
        if (bus.count !== 4'd7) begin
            errors++; $display("FAIL ovf_count got %0d exp 7", bus.count);
        end
        checks++;
        if (flags() !== 6'b000110) begin
            errors++; $display("FAIL ovf_flags got %b exp 000110", flags());
        end
        for (int i = 2; i <= 8; i++) begin
            exp = 8'(i * 8'h11);
            checks++;
            if (bus.data_out !== exp) begin
                errors++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, bus.data_out, exp);
            end
            bus.rd = 1'b1;
            tick();
        end
        idle();
        checks++;
        if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky empty %b ovf %b exp 1 1", bus.empty, bus.overflow);
        end
    endtask

    task automatic test_underflow_flush();
        bus.rd = 1'b1; bus.wr = 1'b1; bus.data_in = 8'h5C;
        tick();
        idle();
        checks++;
        if (bus.count !== 4'd1 || bus.data_out !== 8'h5C) begin
            errors++; $display("FAIL unf_wr count %0d data %h exp 1 5c", bus.count, bus.data_out);
        end
        checks++;
        if (flags() !== 6'b001011) begin
            errors++; $display("FAIL unf_flags got %b exp 001011", flags());
        end
        // Flush with a concurrent write: the write must be ignored.
        bus.flush = 1'b1; bus.wr = 1'b1; bus.data_in = 8'hEE;
        tick();
        idle();
        checks++;
        if (bus.count !== 4'd0 || flags() !== 6'b101000) begin
            errors++; $display("FAIL flush count %0d flags %b exp 0 101000", bus.count, flags());
        end
        tick();
        checks++;
        if (bus.count !== 4'd0) begin
            errors++; $display("FAIL flush_hold count got %0d exp 0", bus.count);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp;
        for (int i = 0; i < 6; i++) begin
            bus.wr = 1'b1; bus.data_in = 8'(i + 1);
            tick();
        end
        idle();
        for (int i = 0; i < 6; i++) begin
            bus.rd = 1'b1;
            tick();
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            bus.wr = 1'b1; bus.data_in = 8'hA1 + 8'(i);
            tick();
        end
        idle();
        checks++;
        if (bus.count !== 4'd5) begin
            errors++; $display("FAIL wrap_count got %0d exp 5", bus.count);
        end
        for (int i = 0; i < 5; i++) begin
            exp = 8'hA1 + 8'(i);
            checks++;
            if (bus.data_out !== exp) begin
                errors++; $display("FAIL wrap_data[%0d] got %h exp %h", i, bus.data_out, exp);
            end
            bus.rd = 1'b1;
            tick();
        end
        idle();
        checks++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
            errors++; $display("FAIL wrap_end count %0d empty %b exp 0 1", bus.count, bus.empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            bus.wr = 1'b1; bus.data_in = 8'h30 + 8'(i);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            exp = 8'h30 + 8'(i);
            bus.wr = 1'b1; bus.rd = 1'b1; bus.data_in = 8'h34 + 8'(i);
            checks++;
            if (bus.data_out !== exp) begin
                errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, bus.data_out, exp);
            end
            tick();
            checks++;
            if (bus.count !== 4'd4) begin
                errors++; $display("FAIL b2b_count[%0d] got %0d exp 4", i, bus.count);
            end
        end
        // Reset mid-stream, with wr/rd still asserted.
        reset = 1'b1;
        tick();
        checks++;
        if (bus.count !== 4'd0 || flags() !== 6'b101000 || bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset count %0d flags %b data %h exp 0 101000 00",
                     bus.count, flags(), bus.data_out);
        end
        reset = 1'b0;
        idle();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow_flush();
        test_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
